// File: rtl/dram_result_uart_framer_if.sv
// Byte-stream bundle between the DRAM read path, the framer and uart_send.
// master = framer side, slave = DRAM core / UART side.
interface dram_result_uart_framer_if;
  logic         rd_done;
  logic [127:0] rd_data;
  logic         tx_en;
  logic [7:0]   tx_data;
  logic         tx_busy;

  modport master (input rd_done, rd_data, tx_busy, output tx_en, tx_data);
  modport slave  (output rd_done, rd_data, tx_busy, input tx_en, tx_data);
endinterface

// File: rtl/dram_result_uart_framer.sv
// Snapshots the 16 DRAM core results on each rd_done rising edge and streams them
// to uart_send as a framed, sequence-numbered, XOR-checksummed packet.

module dram_result_uart_framer_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             ld_act_i,
  input  logic             mv_act_i,
  input  logic             ld_pend_i,
  input  logic [VEC_W-1:0] rd_byte_i,
  output logic [VEC_W-1:0] act_o
);
  logic [VEC_W-1:0] act_q, pend_q;

  // A direct load from rd_data wins over promoting the pending byte; the FSM
  // never asserts both, but the priority keeps the lane self-consistent.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= '0;
      pend_q <= '0;
    end else begin
      if (ld_act_i)      act_q <= rd_byte_i;
      else if (mv_act_i) act_q <= pend_q;
      if (ld_pend_i)     pend_q <= rd_byte_i;
    end
  end

  assign act_o = act_q;
endmodule

module dram_result_uart_framer #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         ACK_TIMEOUT = 4
) (
  input  logic                              clk_100m,
  input  logic                              rst_n,
  dram_result_uart_framer_if.master         bus,
  output logic                              frame_active,
  output logic [7:0]                        frame_cnt,
  output logic [7:0]                        overrun_cnt
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;
  localparam int TW        = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_e;

  state_e                             state_q;
  logic                               rd_d_q;
  logic                               pend_valid_q;
  logic [4:0]                         idx_q;
  logic [7:0]                         seq_q;
  logic [7:0]                         csum_q;
  logic [TW-1:0]                      to_q;
  logic                               tx_en_q;
  logic [7:0]                         tx_data_q;
  logic                               frame_active_q;
  logic [7:0]                         frame_cnt_q;
  logic [7:0]                         overrun_cnt_q;

  logic [NUM_LANES-1:0][VEC_W-1:0]    rd_vec, act_vec;
  logic                               edge_w, last_done, start_idle;
  logic                               act_ld, act_mv, pend_ld, ovr;
  logic [7:0]                         byte_d;

  assign rd_vec = bus.rd_data;
  assign edge_w = bus.rd_done & ~rd_d_q;

  // A completion cycle counts as "frame active": an edge there either becomes
  // the next frame directly (nothing pending) or is dropped (pending full).
  assign last_done  = (state_q == WAIT_DONE) && !bus.tx_busy && (idx_q == 5'd18);
  assign start_idle = (state_q == IDLE) && edge_w;
  assign act_mv     = last_done && pend_valid_q;
  assign act_ld     = start_idle || (last_done && !pend_valid_q && edge_w);
  assign pend_ld    = edge_w && (state_q != IDLE) && !last_done && !pend_valid_q;
  assign ovr        = edge_w && (state_q != IDLE) && pend_valid_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dram_result_uart_framer_lane #(.VEC_W(VEC_W)) u_lane (
      .clk_100m  (clk_100m),
      .rst_n     (rst_n),
      .ld_act_i  (act_ld),
      .mv_act_i  (act_mv),
      .ld_pend_i (pend_ld),
      .rd_byte_i (rd_vec[g]),
      .act_o     (act_vec[g])
    );
  end

  // Byte 2..17 maps to core (idx-2); mod-16 arithmetic on the low bits is exact.
  always_comb begin
    byte_d = act_vec[idx_q[3:0] - 4'd2];
    if (idx_q == 5'd0)       byte_d = HEADER;
    else if (idx_q == 5'd1)  byte_d = seq_q;
    else if (idx_q == 5'd18) byte_d = csum_q;
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rd_d_q         <= 1'b0;
      pend_valid_q   <= 1'b0;
      idx_q          <= '0;
      seq_q          <= '0;
      csum_q         <= '0;
      to_q           <= '0;
      tx_en_q        <= 1'b0;
      tx_data_q      <= '0;
      frame_active_q <= 1'b0;
      frame_cnt_q    <= '0;
      overrun_cnt_q  <= '0;
    end else begin
      rd_d_q  <= bus.rd_done;
      tx_en_q <= 1'b0;
      if (ovr && overrun_cnt_q != 8'hFF) overrun_cnt_q <= overrun_cnt_q + 8'd1;
      if (pend_ld) pend_valid_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start_idle) begin
            seq_q          <= frame_cnt_q;
            idx_q          <= '0;
            csum_q         <= '0;
            frame_active_q <= 1'b1;
            state_q        <= SEND;
          end
        end
        SEND: begin
          if (!bus.tx_busy) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= byte_d;
            if (idx_q != 5'd0 && idx_q != 5'd18) csum_q <= csum_q ^ byte_d;
            to_q      <= '0;
            state_q   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.tx_busy || to_q == TW'(ACK_TIMEOUT)) state_q <= WAIT_DONE;
          else                                         to_q    <= to_q + 1'b1;
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (idx_q != 5'd18) begin
              idx_q   <= idx_q + 5'd1;
              state_q <= SEND;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
              if (act_mv || act_ld) begin
                seq_q        <= frame_cnt_q + 8'd1;
                idx_q        <= '0;
                csum_q       <= '0;
                pend_valid_q <= 1'b0;
                state_q      <= SEND;
              end else begin
                frame_active_q <= 1'b0;
                state_q        <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = tx_data_q;
  assign frame_active = frame_active_q;
  assign frame_cnt    = frame_cnt_q;
  assign overrun_cnt  = overrun_cnt_q;
endmodule

// File: tb/tb_dram_result_uart_framer.sv
// Directed bench: UART responder on the falling edge, byte log, hand-computed frames.
module tb_dram_result_uart_framer;
  logic       clk_100m = 1'b0;
  logic       rst_n    = 1'b0;
  logic       frame_active;
  logic [7:0] frame_cnt, overrun_cnt;

  dram_result_uart_framer_if u_if ();

  dram_result_uart_framer u_dut (
    .clk_100m     (clk_100m),
    .rst_n        (rst_n),
    .bus          (u_if.master),
    .frame_active (frame_active),
    .frame_cnt    (frame_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         cyc = 0;
  int         busy_len = 10;
  int         busy_cnt = 0;
  int         proto_err = 0;
  logic       hold_busy = 1'b0;
  logic [7:0] log_q[$];
  int         ts_q[$];

  always @(posedge clk_100m) cyc <= cyc + 1;

  // uart_send model: logs each tx_en byte, then holds busy for busy_len cycles.
  initial u_if.tx_busy = 1'b0;
  always @(negedge clk_100m) begin
    if (u_if.tx_en === 1'b1) begin
      if (u_if.tx_busy) proto_err++;
      log_q.push_back(u_if.tx_data);
      ts_q.push_back(cyc);
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    u_if.tx_busy = hold_busy || (busy_cnt > 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k = 0;
    while (log_q.size() < n && k < 5000) begin tick(1); k++; end
    check(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (frame_active && k < 5000) begin tick(1); k++; end
    check(tag, 32'(frame_active), 32'd0);
  endtask

  task automatic pulse(input logic [127:0] d);
    u_if.rd_data = d;
    u_if.rd_done = 1'b1;
    tick(1);
    u_if.rd_done = 1'b0;
    tick(1);
  endtask

  task automatic chk_frame(input string tag, input int base, input logic [7:0] seq,
                           input logic [127:0] d, input logic [7:0] chk);
    logic [7:0] e [19];
    e[0] = 8'hA5;
    e[1] = seq;
    for (int j = 0; j < 16; j++) e[j+2] = d[8*j +: 8];
    e[18] = chk;
    for (int j = 0; j < 19; j++)
      check($sformatf("%s[%0d]", tag, j), {24'h0, log_q[base+j]}, {24'h0, e[j]});
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    u_if.rd_done = 1'b0;
    u_if.rd_data = '0;
    hold_busy    = 1'b0;
    tick(14);
    log_q.delete();
    ts_q.delete();
    rst_n = 1'b1;
    tick(2);
  endtask

  logic [127:0] ramp;
  int           sz;

  initial begin
    for (int i = 0; i < 16; i++) ramp[8*i +: 8] = 8'(i + 1);
    u_if.rd_done = 1'b0;
    u_if.rd_data = '0;
    rst_n = 1'b0;
    tick(2);
    check("rst_tx_en", 32'(u_if.tx_en), 32'd0);
    check("rst_tx_data", 32'(u_if.tx_data), 32'd0);
    check("rst_frame_active", 32'(frame_active), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);

    // 1: ramp data, single pulse, latency, rd_data changes after snapshot
    do_reset();
    busy_len = 10;
    u_if.rd_data = ramp;
    u_if.rd_done = 1'b1;
    tick(1);
    check("t1_active_k", 32'(frame_active), 32'd1);
    check("t1_tx_en_k", 32'(u_if.tx_en), 32'd0);
    u_if.rd_done = 1'b0;
    tick(1);
    check("t1_tx_en_k1", 32'(u_if.tx_en), 32'd1);
    check("t1_tx_data_k1", 32'(u_if.tx_data), 32'hA5);
    u_if.rd_data = {4{32'hDEADBEEF}};
    wait_bytes("t1_wait", 19);
    wait_idle("t1_idle");
    check("t1_nbytes", 32'(log_q.size()), 32'd19);
    chk_frame("t1", 0, 8'h00, ramp, 8'h10);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // 2: rd_done held high for 1000 cycles gives one frame
    do_reset();
    u_if.rd_data = {16{8'h55}};
    u_if.rd_done = 1'b1;
    tick(1000);
    check("t2_nbytes", 32'(log_q.size()), 32'd19);
    check("t2_active", 32'(frame_active), 32'd0);
    u_if.rd_done = 1'b0;
    tick(5);
    chk_frame("t2", 0, 8'h00, {16{8'h55}}, 8'h00);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd1);

    // 3: second edge during byte 5 gives a back-to-back second frame
    do_reset();
    pulse(ramp);
    wait_bytes("t3_wait5", 5);
    pulse({16{8'hAA}});
    wait_bytes("t3_wait38", 38);
    wait_idle("t3_idle");
    chk_frame("t3a", 0, 8'h00, ramp, 8'h10);
    chk_frame("t3b", 19, 8'h01, {16{8'hAA}}, 8'h01);
    check("t3_overrun", 32'(overrun_cnt), 32'd0);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd2);

    // 4: three edges in one frame, then overrun saturation under a stuck UART
    do_reset();
    pulse({16{8'h11}});
    wait_bytes("t4_wait3", 3);
    pulse({16{8'h22}});
    pulse({16{8'h33}});
    wait_bytes("t4_wait38", 38);
    wait_idle("t4_idle");
    check("t4_nbytes", 32'(log_q.size()), 32'd38);
    chk_frame("t4a", 0, 8'h00, {16{8'h11}}, 8'h00);
    chk_frame("t4b", 19, 8'h01, {16{8'h22}}, 8'h01);
    check("t4_overrun", 32'(overrun_cnt), 32'd1);
    pulse({16{8'h44}});
    wait_bytes("t4_wait_hdr", 39);
    hold_busy = 1'b1;
    tick(3);
    for (int i = 0; i < 260; i++) pulse({16{8'(i)}});
    check("t4_overrun_sat", 32'(overrun_cnt), 32'hFF);
    check("t4_active_stuck", 32'(frame_active), 32'd1);
    hold_busy = 1'b0;

    // 5: UART never acknowledges; timeout paces bytes 7 cycles apart
    do_reset();
    busy_len = 0;
    pulse(ramp);
    wait_bytes("t5_wait", 19);
    wait_idle("t5_idle");
    chk_frame("t5", 0, 8'h00, ramp, 8'h10);
    for (int j = 1; j < 19; j++)
      check($sformatf("t5_gap[%0d]", j), 32'(ts_q[j] - ts_q[j-1]), 32'd7);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd1);
    busy_len = 10;

    // 6: reset mid-frame with a pending snapshot
    do_reset();
    pulse(ramp);
    wait_bytes("t6_wait3", 3);
    pulse({16{8'h77}});
    wait_bytes("t6_wait9", 9);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx_en", 32'(u_if.tx_en), 32'd0);
    check("t6_rst_tx_data", 32'(u_if.tx_data), 32'd0);
    check("t6_rst_active", 32'(frame_active), 32'd0);
    check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t6_rst_overrun", 32'(overrun_cnt), 32'd0);
    tick(3);
    sz = log_q.size();
    rst_n = 1'b1;
    tick(60);
    check("t6_no_tx", 32'(log_q.size()), 32'(sz));
    check("t6_idle", 32'(frame_active), 32'd0);
    pulse({16{8'h0F}});
    wait_bytes("t6_wait_new", sz + 19);
    wait_idle("t6_idle2");
    chk_frame("t6", sz, 8'h00, {16{8'h0F}}, 8'h00);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);

    check("tx_en_vs_busy", 32'(proto_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
